// File: rtl/ysyx_25040109_mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: shift-add multiplier and restoring
// divider sharing one accumulator, with a valid/ready request and result handshake.
module ysyx_25040109_mdu_seq #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_FAST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    input  logic [4:0]        rd_addr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [4:0]        out_rd_addr,
    output logic              busy
);
    localparam int unsigned WW = 2 * XLEN;
    localparam int unsigned CW = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state, state_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [2:0]      op, op_nxt;
    logic [4:0]      tag, tag_nxt;
    logic            neg_a, neg_a_nxt, neg_b, neg_b_nxt;
    logic [XLEN-1:0] mcand, mcand_nxt;
    logic [WW-1:0]   acc, acc_nxt;
    logic [XLEN-1:0] rem, rem_nxt;
    logic            out_valid_nxt;
    logic [XLEN-1:0] result_nxt;
    logic [4:0]      out_rd_addr_nxt;

    logic            a_sgn, b_sgn, in_neg_a, in_neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf, fast_mul;
    logic [WW-1:0]   fast_mag, fast_fix, prod_fix;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] quo_fix, rem_fix, special_val;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Operand decode at accept: signedness per op, magnitudes and special cases.
    always_comb begin
        a_sgn    = funct3[2] ? !funct3[0] : (funct3[1:0] != 2'b11);
        b_sgn    = funct3[2] ? !funct3[0] : !funct3[1];
        in_neg_a = a_sgn & src_a[XLEN-1];
        in_neg_b = b_sgn & src_b[XLEN-1];
        mag_a    = in_neg_a ? -src_a : src_a;
        mag_b    = in_neg_b ? -src_b : src_b;
        div_zero = funct3[2] && (src_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}})
                   && (src_b == '1);
        fast_mul = (MUL_FAST != 0) && !funct3[2];
        fast_mag = WW'(mag_a) * WW'(mag_b);
        fast_fix = (in_neg_a ^ in_neg_b) ? -fast_mag : fast_mag;
        if (div_zero)
            special_val = funct3[1] ? src_a : '1;
        else if (div_ovf)
            special_val = funct3[1] ? '0 : src_a;
        else
            special_val = (funct3[1:0] == 2'b00) ? fast_fix[XLEN-1:0] : fast_fix[WW-1:XLEN];
    end

    // Per-iteration datapath and sign correction of the finished magnitudes.
    always_comb begin
        mul_sum   = {1'b0, acc[WW-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        div_shift = {rem, acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand};
        prod_fix  = (neg_a ^ neg_b) ? -acc : acc;
        quo_fix   = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix   = neg_a ? -rem : rem;
    end

    always_comb begin
        state_nxt       = state;
        count_nxt       = count;
        op_nxt          = op;
        tag_nxt         = tag;
        neg_a_nxt       = neg_a;
        neg_b_nxt       = neg_b;
        mcand_nxt       = mcand;
        acc_nxt         = acc;
        rem_nxt         = rem;
        out_valid_nxt   = out_valid;
        result_nxt      = result;
        out_rd_addr_nxt = out_rd_addr;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    op_nxt    = funct3;
                    tag_nxt   = rd_addr;
                    neg_a_nxt = in_neg_a;
                    neg_b_nxt = in_neg_b;
                    mcand_nxt = mag_b;
                    acc_nxt   = {{XLEN{1'b0}}, mag_a};
                    rem_nxt   = '0;
                    count_nxt = '0;
                    if (div_zero || div_ovf || fast_mul) begin
                        state_nxt       = S_DONE;
                        out_valid_nxt   = 1'b1;
                        result_nxt      = special_val;
                        out_rd_addr_nxt = rd_addr;
                    end else begin
                        state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!op[2]) begin
                    acc_nxt = {mul_sum, acc[XLEN-1:1]};
                end else begin
                    rem_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                    acc_nxt[XLEN-1:0] = {acc[XLEN-2:0], !div_diff[XLEN]};
                end
                count_nxt = count + CW'(1);
                if (count == CW'(XLEN - 1))
                    state_nxt = S_FIX;
            end
            S_FIX: begin
                state_nxt       = S_DONE;
                out_valid_nxt   = 1'b1;
                out_rd_addr_nxt = tag;
                if (op[2])
                    result_nxt = op[1] ? rem_fix : quo_fix;
                else
                    result_nxt = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[WW-1:XLEN];
            end
            default: begin
                if (out_ready) begin
                    state_nxt     = S_IDLE;
                    out_valid_nxt = 1'b0;
                end
            end
        endcase
        // Flush wins over accept and handshake; the last result stays visible.
        if (flush) begin
            state_nxt       = S_IDLE;
            out_valid_nxt   = 1'b0;
            result_nxt      = result;
            out_rd_addr_nxt = out_rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            op          <= '0;
            tag         <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            mcand       <= '0;
            acc         <= '0;
            rem         <= '0;
            out_valid   <= 1'b0;
            result      <= '0;
            out_rd_addr <= '0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            op          <= op_nxt;
            tag         <= tag_nxt;
            neg_a       <= neg_a_nxt;
            neg_b       <= neg_b_nxt;
            mcand       <= mcand_nxt;
            acc         <= acc_nxt;
            rem         <= rem_nxt;
            out_valid   <= out_valid_nxt;
            result      <= result_nxt;
            out_rd_addr <= out_rd_addr_nxt;
        end
    end
endmodule

// File: tb/tb_ysyx_25040109_mdu_seq.sv
// Bench for the RV32M sequencer: directed vector table, random ops against an
// arithmetic reference, and hand-written handshake, flush and reset sequences.
module tb_ysyx_25040109_mdu_seq;
    logic        clk = 1'b0;
    logic        rst, in_valid, flush, out_ready;
    logic [2:0]  funct3;
    logic [31:0] src_a, src_b;
    logic [4:0]  rd_addr;
    logic        in_ready, out_valid, busy;
    logic [31:0] result;
    logic [4:0]  out_rd_addr;
    logic        f_in_valid, f_in_ready, f_out_valid, f_busy;
    logic [31:0] f_result;
    logic [4:0]  f_out_rd_addr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ysyx_25040109_mdu_seq #(.XLEN(32), .MUL_FAST(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .src_a(src_a), .src_b(src_b), .rd_addr(rd_addr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_rd_addr(out_rd_addr), .busy(busy));

    ysyx_25040109_mdu_seq #(.XLEN(32), .MUL_FAST(1)) dut_fast (
        .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .funct3(funct3), .src_a(src_a), .src_b(src_b), .rd_addr(rd_addr),
        .flush(flush), .out_valid(f_out_valid), .out_ready(1'b1),
        .result(f_result), .out_rd_addr(f_out_rd_addr), .busy(f_busy));

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                                logic [4:0] rd, logic [31:0] exp, int lat);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    // Reference: full-width 64-bit arithmetic, SV division truncates toward zero.
    function automatic logic [31:0] model(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int model_lat(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one op at a negedge, accept on the next posedge, then scramble inputs.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input string nm);
        @(negedge clk);
        funct3 = f3; src_a = a; src_b = b; rd_addr = rd; in_valid = 1'b1;
        chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        funct3 = 3'($urandom); src_a = $urandom; src_b = $urandom; rd_addr = 5'($urandom);
    endtask

    // Counts negedges after the accept edge until out_valid; ends on that negedge.
    task automatic collect(input logic [31:0] exp, input logic [4:0] rd, input int lat,
                           input string nm);
        int n = 0;
        bit got = 0;
        while (n < 100 && !got) begin
            @(negedge clk);
            n++;
            if (out_valid) got = 1;
        end
        chk({nm, ".latency"}, got ? 32'(n) : 32'hDEAD_BEEF, 32'(lat));
        chk({nm, ".result"}, result, exp);
        chk({nm, ".rd"}, 32'(out_rd_addr), 32'(rd));
    endtask

    task automatic take(input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({nm, ".valid_drop"}, 32'(out_valid), 32'd0);
        chk({nm, ".ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a, b, e;
        logic [2:0]  f;
        logic [4:0]  rd;
        bit          seen;

        rst = 1'b1; in_valid = 1'b0; f_in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        funct3 = '0; src_a = '0; src_b = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.rd", 32'(out_rd_addr), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        vecs.push_back(mk(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34));
        vecs.push_back(mk(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 34));
        vecs.push_back(mk(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34));
        vecs.push_back(mk(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd3,  32'hFFFF_FFFF, 34));
        vecs.push_back(mk(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD, 34));
        vecs.push_back(mk(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 34));
        vecs.push_back(mk(3'd5, 32'hFFFF_FFFF,  32'd2,         5'd7,  32'h7FFF_FFFF, 34));
        vecs.push_back(mk(3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         34));
        vecs.push_back(mk(3'd4, 32'h0001_2345,  32'd0,         5'd9,  32'hFFFF_FFFF, 1));
        vecs.push_back(mk(3'd7, 32'h0000_1234,  32'd0,         5'd10, 32'h0000_1234, 1));
        vecs.push_back(mk(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1));
        vecs.push_back(mk(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0,         1));
        vecs.push_back(mk(3'd5, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1));
        vecs.push_back(mk(3'd6, 32'd7,          32'd0,         5'd14, 32'd7,         1));
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, $sformatf("vec%0d", i));
            collect(vecs[i].exp, vecs[i].rd, vecs[i].lat, $sformatf("vec%0d", i));
            take($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = -32'($urandom_range(0, 1000));
                default: ;
            endcase
            rd = 5'($urandom);
            e = model(f, a, b);
            issue(f, a, b, rd, $sformatf("rnd%0d", i));
            collect(e, rd, model_lat(f, a, b), $sformatf("rnd%0d", i));
            take($sformatf("rnd%0d", i));
        end

        // Backpressure, then a back-to-back op on the first cycle in_ready returns.
        issue(3'd5, 32'd1000, 32'd10, 5'd9, "bp");
        collect(32'd100, 5'd9, 34, "bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp.hold%0d.valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp.hold%0d.result", i), result, 32'd100);
            chk($sformatf("bp.hold%0d.rd", i), 32'(out_rd_addr), 32'd9);
            chk($sformatf("bp.hold%0d.in_ready", i), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        funct3 = 3'd7; src_a = 32'd100; src_b = 32'd7; rd_addr = 5'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp.ready_after", 32'(in_ready), 32'd1);
        chk("bp.valid_after", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom;
        collect(32'd2, 5'd3, 34, "b2b");
        take("b2b");

        // Flush mid-CALC: idle next cycle, the aborted op never reports.
        issue(3'd0, 32'd9, 32'd9, 5'd17, "fl");
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl.in_ready", 32'(in_ready), 32'd1);
        chk("fl.busy", 32'(busy), 32'd0);
        chk("fl.result_kept", result, 32'd2);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("fl.no_valid", 32'(seen), 32'd0);

        // Flush with in_valid in IDLE: a special op that would report at once is dropped.
        @(negedge clk);
        funct3 = 3'd4; src_a = 32'd5; src_b = 32'd0; rd_addr = 5'd20;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flacc.in_ready", 32'(in_ready), 32'd1);
        chk("flacc.valid", 32'(out_valid), 32'd0);

        // Flush coinciding with out_ready in DONE drops the result.
        issue(3'd7, 32'd77, 32'd0, 5'd21, "fld");
        collect(32'd77, 5'd21, 1, "fld");
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; out_ready = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("fld.no_valid", 32'(seen), 32'd0);

        // Reset mid-CALC returns every output to its reset value.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd22, "rmid");
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rmid.out_valid", 32'(out_valid), 32'd0);
        chk("rmid.result", result, 32'd0);
        chk("rmid.rd", 32'(out_rd_addr), 32'd0);
        chk("rmid.busy", 32'(busy), 32'd0);
        chk("rmid.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Fast-multiply build completes a MUL one cycle after accept.
        @(negedge clk);
        funct3 = 3'd0; src_a = 32'd7; src_b = 32'hFFFF_FFFD; rd_addr = 5'd6;
        f_in_valid = 1'b1;
        chk("fast.in_ready", 32'(f_in_ready), 32'd1);
        @(posedge clk);
        #1;
        f_in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom;
        @(negedge clk);
        chk("fast.valid", 32'(f_out_valid), 32'd1);
        chk("fast.result", f_result, 32'hFFFF_FFEB);
        chk("fast.rd", 32'(f_out_rd_addr), 32'd6);
        @(negedge clk);
        funct3 = 3'd1; src_a = 32'h8000_0000; src_b = 32'h8000_0000; rd_addr = 5'd7;
        f_in_valid = 1'b1;
        @(posedge clk);
        #1;
        f_in_valid = 1'b0;
        @(negedge clk);
        chk("fast.mulh.valid", 32'(f_out_valid), 32'd1);
        chk("fast.mulh.result", f_result, 32'h4000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
